// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and default widths for DataPath memory clients.
package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  typedef logic [1:0] owner_t;

  localparam owner_t OWN_NONE = 2'd0;
  localparam owner_t OWN_IF   = 2'd1;
  localparam owner_t OWN_LS   = 2'd2;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between IF and LS with an IF anti-starvation counter.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic issue_ok_i,
  input  logic if_req_i,
  input  logic if_flush_i,
  input  logic ls_req_i,
  output logic if_gnt_o,
  output logic ls_gnt_o
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             if_eff;
  logic             starved;

  // A flushing IF must not be granted, so it never counts as contending.
  assign if_eff  = if_req_i & ~if_flush_i;
  assign starved = (starve_q == CNT_W'(MAX_WAIT));

  // Combinational grant: LS by default, IF when alone or starved.
  always_comb begin
    if_gnt_o = 1'b0;
    ls_gnt_o = 1'b0;
    if (issue_ok_i) begin
      if (if_eff && (!ls_req_i || starved)) begin
        if_gnt_o = 1'b1;
      end else if (ls_req_i) begin
        ls_gnt_o = 1'b1;
      end
    end
  end

  // Count LS wins over a live IF request; saturating, cleared by IF grant or idle IF.
  always_comb begin
    starve_d = starve_q;
    if (!if_req_i || if_gnt_o) begin
      starve_d = '0;
    end else if (ls_gnt_o && if_eff && !starved) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port unified memory between instruction fetch and load/store.
// One transaction outstanding; issue allowed when idle or in the response cycle.
//
// state   | meaning
// --------+------------------------------------------------
// ST_IDLE | no transaction outstanding
// ST_WAIT | one transaction outstanding, lat_cnt counting down
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MEM_LAT  = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [DATA_W/8-1:0] ls_be,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  logic [0:0]       state_q, state_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  owner_t           owner_q, owner_d;
  logic             squash_q, squash_d;
  logic             resp;
  logic             issue_ok;

  assign resp = (state_q == ST_WAIT) && (lat_cnt_q == '0);

  // Grants are held off while reset is asserted so every output reads 0.
  assign issue_ok = rst & ((state_q == ST_IDLE) | resp);

  mem_arb_pick #(
    .MAX_WAIT (MAX_WAIT)
  ) u_pick (
    .clk        (clk),
    .rst        (rst),
    .issue_ok_i (issue_ok),
    .if_req_i   (if_req),
    .if_flush_i (if_flush),
    .ls_req_i   (ls_req),
    .if_gnt_o   (if_gnt),
    .ls_gnt_o   (ls_gnt)
  );

  // Next-state: response cycle retires, a same-cycle issue restarts the countdown.
  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    owner_d   = owner_q;
    if (resp) begin
      state_d   = ST_IDLE;
      owner_d   = OWN_NONE;
      lat_cnt_d = '0;
    end else if (state_q == ST_WAIT) begin
      lat_cnt_d = lat_cnt_q - 1'b1;
    end
    if (if_gnt || ls_gnt) begin
      state_d   = ST_WAIT;
      owner_d   = if_gnt ? OWN_IF : OWN_LS;
      lat_cnt_d = LAT_W'(MEM_LAT - 1);
    end
  end

  // Squash remembers a flush seen while IF owned the transaction, until it retires.
  always_comb begin
    squash_d = squash_q;
    if (resp) begin
      squash_d = 1'b0;
    end else if ((state_q == ST_WAIT) && (owner_q == OWN_IF) && if_flush) begin
      squash_d = 1'b1;
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      lat_cnt_q <= '0;
      owner_q   <= OWN_NONE;
      squash_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      owner_q   <= owner_d;
      squash_q  <= squash_d;
    end
  end

  // Route the response to the owner; a flush in the response cycle itself also squashes.
  always_comb begin
    if_rvalid = resp && (owner_q == OWN_IF) && !squash_q && !if_flush;
    ls_rvalid = resp && (owner_q == OWN_LS);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    ls_rdata  = ls_rvalid ? mem_rdata : '0;
  end

  // Memory request mux; fields read 0 when no access is issued.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ls_gnt) begin
      mem_en    = 1'b1;
      mem_we    = ls_we;
      mem_be    = ls_be;
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
    end else if (if_gnt) begin
      mem_en    = 1'b1;
      mem_be    = '1;
      mem_addr  = if_addr;
    end
  end

endmodule
